top: RTL and testbench
======================

# top

Top-level wrapper of the five-stage pipelined RV32I-subset processor. It contains the complete core: program counter, instruction memory, register file, ALU, data memory, pipeline registers and hazard unit, all in one instance. It has no external data ports; benches preload the memories and register file hierarchically and observe state through them. It is the root of the processor design.

## Interface
- No parameters. Sizes are fixed: 32-bit datapath, 64-word instruction memory, 64-word data memory, 32 × 32-bit register file.
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset. While low at a rising clk edge, the PC and all pipeline registers clear.
- Required hierarchy, which benches preload with $readmemh at time 0:
  - RISCVPipeline.InstructionMemory.instruction_memory: [0:63] of 32 bits.
  - RISCVPipeline.DataMemory.data_memory: [0:63] of 32 bits.
  - RISCVPipeline.RegisterFile.registers: [0:31] of 32 bits.

## Operation
- Stages: IF, ID, EX, MEM, WB, separated by registers IF/ID, ID/EX, EX/MEM and MEM/WB.
- Supported instructions: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal.
  - Any other encoding executes as a NOP: no register write, no memory write, no branch.
- Immediate types: I, S, B and J, sign-extended. slt/slti compare signed.
- Register file:
  - Two combinational read ports and one write port.
  - x0 always reads 0; writes to x0 are discarded.
  - Write-through: a WB write to rd is visible to an ID read of the same register in the same cycle.
- Instruction memory: word-indexed by PC[7:2], combinational read. PC bits above bit 7 are ignored, so addresses wrap modulo 256 bytes.
- Data memory: word-indexed by ALU result [7:2].
  - Combinational read.
  - Write on the rising clk edge when MemWrite is set.
  - Byte offset bits [1:0] are ignored.
- Branch and jump:
  - beq and jal resolve in EX; the target is PC_EX + imm.
  - jal writes PC_EX + 4 to rd.
  - A taken branch/jump flushes IF/ID and ID/EX, which become bubbles, and loads the target into the PC.
- Load-use hazard: an lw in EX whose rd (nonzero) matches rs1 or rs2 in ID causes a one-cycle stall.
  - PC and IF/ID hold.
  - ID/EX is loaded with a bubble.
- Reset:
  - PC becomes 0 and all pipeline registers become bubbles (all control signals 0).
  - Register file contents and both memories are NOT cleared, so preloaded contents survive reset.

## Timing
- The first instruction is fetched from address 0 on the first rising edge after reset goes high.
- An instruction's register result is written 4 cycles after its fetch edge, i.e. at its WB edge.
- Store memory write occurs at the MEM-stage edge.
- Throughput is 1 instruction per cycle, except:
  - +1 cycle per load-use stall.
  - +2 cycles per taken beq/jal.
- Simultaneous stall and taken branch: the flush wins. The PC loads the target and IF/ID and ID/EX are flushed.
- Reset asserted mid-program: effective at the next rising edge. Instructions in flight are discarded and any register or memory writes already committed remain.

## Configuration
- PIPE_FORWARDING_EN defined:
  - The forwarding unit bypasses EX/MEM and MEM/WB results to the EX operands (EX/MEM has priority). Rd = x0 is never forwarded.
  - Only load-use hazards stall.
- PIPE_FORWARDING_EN undefined:
  - No bypass paths.
  - The hazard unit stalls any ID instruction whose nonzero rs1/rs2 matches rd of a register-writing instruction in EX or MEM, until the producer reaches WB.
  - Architectural results are identical in both modes; only cycle counts differ.

## Test plan
- Reset retention:
  - Stimulus: preload registers[5]=32'h0000_0007 and data_memory[0]=32'hDEAD_BEEF; hold reset low 8 cycles with NOPs in memory.
  - Response: both values unchanged after release; PC=0 during reset.
- ALU chain:
  - Stimulus: program "addi x1,x0,5; addi x2,x0,12; add x3,x1,x2; sub x4,x3,x1; and x5,x3,x2; or x6,x1,x2; slt x7,x1,x2".
  - Response: x3=17, x4=12, x5=0, x6=13, x7=1.
  - Repeat with and without PIPE_FORWARDING_EN; results must be identical.
- Load-use:
  - Stimulus: data_memory[1]=32'd40; program "lw x1,4(x0); add x2,x1,x1; sw x2,8(x0)".
  - Response: data_memory[2]=80; exactly one stall cycle with forwarding enabled.
- Branch flush:
  - Stimulus: program "addi x1,x0,3; beq x1,x1,+12; addi x2,x0,1; addi x3,x0,1; addi x4,x0,9".
  - Response: x2=0, x3=0, x4=9.
- jal link:
  - Stimulus: jal x1,+8 at address 0x10.
  - Response: x1=0x14; the instruction at 0x14 is not executed; the instruction at 0x18 is executed.
- x0 protection:
  - Stimulus: "addi x0,x0,55; add x1,x0,x0".
  - Response: x0 reads 0 and x1=0.

Source files
------------

// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- five-stage pipelined RV32I-subset processor (IF/ID/EX/MEM/WB).
//
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   reset  : synchronous active-low reset; clears PC and pipeline registers
//
// Hierarchy kept stable for preload/observation:
//   RISCVPipeline.InstructionMemory.instruction_memory [0:63]
//   RISCVPipeline.DataMemory.data_memory              [0:63]
//   RISCVPipeline.RegisterFile.registers              [0:31]
//
// Build option: PIPE_FORWARDING_EN
//   defined   -> EX/MEM and MEM/WB bypass to EX operands, only load-use stalls
//   undefined -> no bypass, ID stalls until the producer reaches WB
// ---------------------------------------------------------------------------

module instruction_memory (
  input  logic [5:0]  addr,
  output logic [31:0] instr
);
  logic [31:0] instruction_memory [0:63];

  assign instr = instruction_memory[addr];
endmodule

module data_memory (
  input  logic        clk,
  input  logic [5:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] data_memory [0:63];

  // Contents are deliberately not reset so preloaded data survives reset.
  always_ff @(posedge clk) begin
    if (we) data_memory[addr] <= wdata;
  end

  assign rdata = data_memory[addr];
endmodule

module register_file (
  input  logic        clk,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        we,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);
  logic [31:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (we && rd_addr != 5'd0) registers[rd_addr] <= wdata;
  end

  // Write-through lets an ID read see the value WB commits on the same edge.
  always_comb begin
    rs1_data = registers[rs1_addr];
    rs2_data = registers[rs2_addr];
    if (rs1_addr == 5'd0) rs1_data = '0;
    else if (we && rd_addr == rs1_addr) rs1_data = wdata;
    if (rs2_addr == 5'd0) rs2_data = '0;
    else if (we && rd_addr == rs2_addr) rs2_data = wdata;
  end
endmodule

module riscv_pipeline (
  input logic clk,
  input logic reset
);
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

  // All-zero control word is a bubble.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_t alu_op;
  } ctrl_t;

  logic [31:0] pc;
  logic [31:0] if_instr;

  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  ctrl_t       idex_ctrl;
  logic [31:0] idex_pc;
  logic [31:0] idex_a;
  logic [31:0] idex_b;
  logic [31:0] idex_imm;
  logic [4:0]  idex_rd;
`ifdef PIPE_FORWARDING_EN
  logic [4:0]  idex_rs1;
  logic [4:0]  idex_rs2;
`endif

  logic        exmem_reg_write;
  logic        exmem_mem_read;
  logic        exmem_mem_write;
  logic [31:0] exmem_result;
  logic [31:0] exmem_store;
  logic [4:0]  exmem_rd;

  logic        memwb_reg_write;
  logic [31:0] memwb_result;
  logic [4:0]  memwb_rd;

  // ---------------- IF ----------------
  instruction_memory InstructionMemory (
    .addr  (pc[7:2]),
    .instr (if_instr)
  );

  // ---------------- ID ----------------
  logic [6:0]  id_op;
  logic [6:0]  id_f7;
  logic [2:0]  id_f3;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  ctrl_t       id_ctrl;
  logic [31:0] id_imm;
  logic [31:0] id_a;
  logic [31:0] id_b;

  assign id_op  = ifid_instr[6:0];
  assign id_rd  = ifid_instr[11:7];
  assign id_f3  = ifid_instr[14:12];
  assign id_rs1 = ifid_instr[19:15];
  assign id_rs2 = ifid_instr[24:20];
  assign id_f7  = ifid_instr[31:25];

  // Unsupported encodings leave id_ctrl at zero and so behave as NOPs.
  always_comb begin
    id_ctrl = '0;
    id_imm  = '0;
    case (id_op)
      7'b0000011: begin
        id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
        if (id_f3 == 3'b010) begin
          id_ctrl.reg_write = 1'b1;
          id_ctrl.mem_read  = 1'b1;
          id_ctrl.alu_src   = 1'b1;
        end
      end
      7'b0100011: begin
        id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
        if (id_f3 == 3'b010) begin
          id_ctrl.mem_write = 1'b1;
          id_ctrl.alu_src   = 1'b1;
        end
      end
      7'b0110011: begin
        id_ctrl.reg_write = 1'b1;
        if (id_f7 == 7'b0000000 && id_f3 == 3'b000)      id_ctrl.alu_op = ALU_ADD;
        else if (id_f7 == 7'b0100000 && id_f3 == 3'b000) id_ctrl.alu_op = ALU_SUB;
        else if (id_f7 == 7'b0000000 && id_f3 == 3'b111) id_ctrl.alu_op = ALU_AND;
        else if (id_f7 == 7'b0000000 && id_f3 == 3'b110) id_ctrl.alu_op = ALU_OR;
        else if (id_f7 == 7'b0000000 && id_f3 == 3'b010) id_ctrl.alu_op = ALU_SLT;
        else                                             id_ctrl.reg_write = 1'b0;
      end
      7'b0010011: begin
        id_imm            = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        case (id_f3)
          3'b000:  id_ctrl.alu_op = ALU_ADD;
          3'b111:  id_ctrl.alu_op = ALU_AND;
          3'b110:  id_ctrl.alu_op = ALU_OR;
          3'b010:  id_ctrl.alu_op = ALU_SLT;
          default: begin
            id_ctrl.reg_write = 1'b0;
            id_ctrl.alu_src   = 1'b0;
          end
        endcase
      end
      7'b1100011: begin
        id_imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                  ifid_instr[30:25], ifid_instr[11:8], 1'b0};
        if (id_f3 == 3'b000) id_ctrl.branch = 1'b1;
      end
      7'b1101111: begin
        id_imm = {{11{ifid_instr[31]}}, ifid_instr[31], ifid_instr[19:12],
                  ifid_instr[20], ifid_instr[30:21], 1'b0};
        id_ctrl.reg_write = 1'b1;
        id_ctrl.jump      = 1'b1;
      end
      default: ;
    endcase
  end

  register_file RegisterFile (
    .clk      (clk),
    .rs1_addr (id_rs1),
    .rs2_addr (id_rs2),
    .we       (memwb_reg_write),
    .rd_addr  (memwb_rd),
    .wdata    (memwb_result),
    .rs1_data (id_a),
    .rs2_data (id_b)
  );

  // ---------------- EX ----------------
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_opb;
  logic [31:0] ex_alu;
  logic [31:0] ex_result;
  logic [31:0] ex_target;
  logic        ex_taken;

`ifdef PIPE_FORWARDING_EN
  // EX/MEM is younger than MEM/WB, so it wins when both match.
  always_comb begin
    ex_a = idex_a;
    ex_b = idex_b;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs1)      ex_a = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1) ex_a = memwb_result;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idex_rs2)      ex_b = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2) ex_b = memwb_result;
  end
`else
  assign ex_a = idex_a;
  assign ex_b = idex_b;
`endif

  assign ex_opb = idex_ctrl.alu_src ? idex_imm : ex_b;

  always_comb begin
    ex_alu = ex_a + ex_opb;
    case (idex_ctrl.alu_op)
      ALU_SUB: ex_alu = ex_a - ex_opb;
      ALU_AND: ex_alu = ex_a & ex_opb;
      ALU_OR:  ex_alu = ex_a | ex_opb;
      ALU_SLT: ex_alu = {31'd0, $signed(ex_a) < $signed(ex_opb)};
      default: ;
    endcase
  end

  // jal carries its link address down the result path.
  assign ex_result = idex_ctrl.jump ? idex_pc + 32'd4 : ex_alu;
  assign ex_target = idex_pc + idex_imm;
  assign ex_taken  = idex_ctrl.jump || (idex_ctrl.branch && ex_a == ex_b);

  // ---------------- hazard ----------------
  function automatic logic id_hit(input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2);
    return (rd != 5'd0) && (rd == rs1 || rd == rs2);
  endfunction

  logic stall;
`ifdef PIPE_FORWARDING_EN
  assign stall = idex_ctrl.mem_read && id_hit(idex_rd, id_rs1, id_rs2);
`else
  // MEM/WB needs no stall: the register file writes through.
  assign stall = (idex_ctrl.reg_write && id_hit(idex_rd, id_rs1, id_rs2)) ||
                 (exmem_reg_write && id_hit(exmem_rd, id_rs1, id_rs2));
`endif

  // ---------------- MEM ----------------
  logic [31:0] mem_rdata;

  data_memory DataMemory (
    .clk   (clk),
    .addr  (exmem_result[7:2]),
    .we    (exmem_mem_write),
    .wdata (exmem_store),
    .rdata (mem_rdata)
  );

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc              <= '0;
      ifid_pc         <= '0;
      ifid_instr      <= '0;
      idex_ctrl       <= '0;
      idex_pc         <= '0;
      idex_a          <= '0;
      idex_b          <= '0;
      idex_imm        <= '0;
      idex_rd         <= '0;
`ifdef PIPE_FORWARDING_EN
      idex_rs1        <= '0;
      idex_rs2        <= '0;
`endif
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_result    <= '0;
      exmem_store     <= '0;
      exmem_rd        <= '0;
      memwb_reg_write <= 1'b0;
      memwb_result    <= '0;
      memwb_rd        <= '0;
    end else begin
      // A taken branch overrides a simultaneous stall.
      if (ex_taken) begin
        pc         <= ex_target;
        ifid_instr <= '0;
      end else if (!stall) begin
        pc         <= pc + 32'd4;
        ifid_pc    <= pc;
        ifid_instr <= if_instr;
      end

      idex_ctrl <= (ex_taken || stall) ? ctrl_t'('0) : id_ctrl;
      idex_pc   <= ifid_pc;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= id_imm;
      idex_rd   <= id_rd;
`ifdef PIPE_FORWARDING_EN
      idex_rs1  <= id_rs1;
      idex_rs2  <= id_rs2;
`endif

      exmem_reg_write <= idex_ctrl.reg_write;
      exmem_mem_read  <= idex_ctrl.mem_read;
      exmem_mem_write <= idex_ctrl.mem_write;
      exmem_result    <= ex_result;
      exmem_store     <= ex_b;
      exmem_rd        <= idex_rd;

      memwb_reg_write <= exmem_reg_write;
      memwb_result    <= exmem_mem_read ? mem_rdata : exmem_result;
      memwb_rd        <= exmem_rd;
    end
  end
endmodule

module top (
  input logic clk,
  input logic reset
);
  riscv_pipeline RISCVPipeline (
    .clk   (clk),
    .reset (reset)
  );
endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top -- bench for the pipelined core. Programs are preloaded into the
// core's memories and register file; an instruction-level reference model
// executes the same program and final architectural state is compared.
// Optional build macro PIPE_FORWARDING_EN selects the expected stall timing.
// ---------------------------------------------------------------------------

module tb_top;
  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  top dut (
    .clk   (clk),
    .reset (reset)
  );

  localparam logic [31:0] HALT = 32'h0000_006F;  // jal x0, 0
  localparam logic [31:0] NOP  = 32'h0000_0013;  // addi x0, x0, 0
`ifdef PIPE_FORWARDING_EN
  localparam logic [31:0] LU_EDGE = 32'd7;
`else
  localparam logic [31:0] LU_EDGE = 32'd10;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] m_imem [0:63];
  logic [31:0] m_dmem [0:63];
  logic [31:0] m_reg  [0:31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] rreg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_reg[r];
  endfunction

  task automatic wreg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  task automatic model_run();
    logic [31:0] pc, nxt, ins, a, b, immi, imms, immb, immj, addr;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    pc = 32'd0;
    for (int s = 0; s < 2000; s++) begin
      ins = m_imem[pc[7:2]];
      if (ins == HALT) break;
      op   = ins[6:0];
      rd   = ins[11:7];
      f3   = ins[14:12];
      f7   = ins[31:25];
      a    = rreg(ins[19:15]);
      b    = rreg(ins[24:20]);
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      nxt  = pc + 32'd4;
      case (op)
        7'h03: if (f3 == 3'd2) begin addr = a + immi; wreg(rd, m_dmem[addr[7:2]]); end
        7'h23: if (f3 == 3'd2) begin addr = a + imms; m_dmem[addr[7:2]] = b; end
        7'h33: begin
          if (f7 == 7'h00 && f3 == 3'd0)      wreg(rd, a + b);
          else if (f7 == 7'h20 && f3 == 3'd0) wreg(rd, a - b);
          else if (f7 == 7'h00 && f3 == 3'd7) wreg(rd, a & b);
          else if (f7 == 7'h00 && f3 == 3'd6) wreg(rd, a | b);
          else if (f7 == 7'h00 && f3 == 3'd2) wreg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        end
        7'h13: begin
          if (f3 == 3'd0)      wreg(rd, a + immi);
          else if (f3 == 3'd7) wreg(rd, a & immi);
          else if (f3 == 3'd6) wreg(rd, a | immi);
          else if (f3 == 3'd2) wreg(rd, ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0);
        end
        7'h63: if (f3 == 3'd0 && a == b) nxt = pc + immb;
        7'h6F: begin wreg(rd, pc + 32'd4); nxt = pc + immj; end
        default: ;
      endcase
      pc = nxt;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin m_dmem[i] = 32'd0; m_imem[i] = HALT; end
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
  endtask

  task automatic set_prog(input logic [31:0] p[$]);
    for (int i = 0; i < 64; i++) m_imem[i] = (i < p.size()) ? p[i] : HALT;
  endtask

  task automatic push_state();
    for (int i = 0; i < 64; i++) begin
      dut.RISCVPipeline.InstructionMemory.instruction_memory[i] = m_imem[i];
      dut.RISCVPipeline.DataMemory.data_memory[i] <= m_dmem[i];
    end
    for (int i = 0; i < 32; i++) dut.RISCVPipeline.RegisterFile.registers[i] <= m_reg[i];
  endtask

  // Assert reset, preload after the first reset edge, release at a negedge.
  task automatic start(input int rst_cycles);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < rst_cycles; r++) begin
      @(posedge clk);
      #1;
      if (r == 0) push_state();
      check("pc_in_reset", dut.RISCVPipeline.pc, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_state(input string tag);
    model_run();
    for (int i = 1; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.RISCVPipeline.RegisterFile.registers[i], m_reg[i]);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_mem%0d", tag, i), dut.RISCVPipeline.DataMemory.data_memory[i], m_dmem[i]);
  endtask

  function automatic logic [31:0] rand_instr(input int idx, input int len);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] r;
    int          span, kind;
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    imm  = 12'($urandom);
    r    = $urandom;
    span = len - idx;
    if (span > 3) span = 3;
    kind = $urandom_range(0, 13);
    case (kind)
      0:  return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
      1:  return enc_s(imm, rs2, rs1);
      2:  return enc_r(7'h00, rs2, rs1, 3'd0, rd);
      3:  return enc_r(7'h20, rs2, rs1, 3'd0, rd);
      4:  return enc_r(7'h00, rs2, rs1, 3'd7, rd);
      5:  return enc_r(7'h00, rs2, rs1, 3'd6, rd);
      6:  return enc_r(7'h00, rs2, rs1, 3'd2, rd);
      7:  return enc_i(imm, rs1, 3'd0, rd, 7'b0010011);
      8:  return enc_i(imm, rs1, 3'd7, rd, 7'b0010011);
      9:  return enc_i(imm, rs1, 3'd6, rd, 7'b0010011);
      10: return enc_i(imm, rs1, 3'd2, rd, 7'b0010011);
      11: begin
        if (r[0]) rs2 = rs1;
        return enc_b(13'($urandom_range(1, span) * 4), rs2, rs1);
      end
      12: return enc_j(21'($urandom_range(1, span) * 4), rd);
      default: return r[1] ? {r[31:7], 7'b0110111} : enc_r(7'h01, rs2, rs1, 3'd0, rd);
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] prog[$];
    logic [31:0] hit_edge;

    // Reset retention with NOPs in memory.
    clear_model();
    for (int i = 0; i < 64; i++) m_imem[i] = NOP;
    m_reg[5]  = 32'h0000_0007;
    m_dmem[0] = 32'hDEAD_BEEF;
    start(8);
    run(10);
    check("ret_x5", dut.RISCVPipeline.RegisterFile.registers[5], 32'h0000_0007);
    check("ret_mem0", dut.RISCVPipeline.DataMemory.data_memory[0], 32'hDEAD_BEEF);

    // ALU chain.
    clear_model();
    prog = {enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011),
            enc_i(12'd12, 5'd0, 3'd0, 5'd2, 7'b0010011),
            enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),
            enc_r(7'h20, 5'd1, 5'd3, 3'd0, 5'd4),
            enc_r(7'h00, 5'd2, 5'd3, 3'd7, 5'd5),
            enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd6),
            enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd7)};
    set_prog(prog);
    start(2);
    run(40);
    check("alu_x3", dut.RISCVPipeline.RegisterFile.registers[3], 32'd17);
    check("alu_x4", dut.RISCVPipeline.RegisterFile.registers[4], 32'd12);
    check("alu_x5", dut.RISCVPipeline.RegisterFile.registers[5], 32'd0);
    check("alu_x6", dut.RISCVPipeline.RegisterFile.registers[6], 32'd13);
    check("alu_x7", dut.RISCVPipeline.RegisterFile.registers[7], 32'd1);
    compare_state("alu");

    // Load-use: store lands at fetch edge of sw + 3, sw delayed by the stall(s).
    clear_model();
    m_dmem[1] = 32'd40;
    prog = {enc_i(12'd4, 5'd0, 3'b010, 5'd1, 7'b0000011),
            enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2),
            enc_s(12'd8, 5'd2, 5'd0)};
    set_prog(prog);
    start(2);
    hit_edge = '1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (hit_edge == '1 && dut.RISCVPipeline.DataMemory.data_memory[2] === 32'd80)
        hit_edge = 32'(e);
    end
    check("lu_mem2", dut.RISCVPipeline.DataMemory.data_memory[2], 32'd80);
    check("lu_store_edge", hit_edge, LU_EDGE);
    compare_state("lu");

    // Branch flush.
    clear_model();
    prog = {enc_i(12'd3, 5'd0, 3'd0, 5'd1, 7'b0010011),
            enc_b(13'd12, 5'd1, 5'd1),
            enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'b0010011),
            enc_i(12'd1, 5'd0, 3'd0, 5'd3, 7'b0010011),
            enc_i(12'd9, 5'd0, 3'd0, 5'd4, 7'b0010011)};
    set_prog(prog);
    start(2);
    run(40);
    check("br_x1", dut.RISCVPipeline.RegisterFile.registers[1], 32'd3);
    check("br_x2", dut.RISCVPipeline.RegisterFile.registers[2], 32'd0);
    check("br_x3", dut.RISCVPipeline.RegisterFile.registers[3], 32'd0);
    check("br_x4", dut.RISCVPipeline.RegisterFile.registers[4], 32'd9);

    // jal link at 0x10.
    clear_model();
    prog = {NOP, NOP, NOP, NOP,
            enc_j(21'd8, 5'd1),
            enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'b0010011),
            enc_i(12'd1, 5'd0, 3'd0, 5'd3, 7'b0010011)};
    set_prog(prog);
    start(2);
    run(40);
    check("jal_x1", dut.RISCVPipeline.RegisterFile.registers[1], 32'h0000_0014);
    check("jal_x2", dut.RISCVPipeline.RegisterFile.registers[2], 32'd0);
    check("jal_x3", dut.RISCVPipeline.RegisterFile.registers[3], 32'd1);

    // x0 protection, with garbage planted in the x0 storage slot.
    clear_model();
    m_reg[0] = 32'h1234_5678;
    m_reg[1] = 32'hFFFF_FFFF;
    prog = {enc_i(12'd55, 5'd0, 3'd0, 5'd0, 7'b0010011),
            enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd1)};
    set_prog(prog);
    start(2);
    run(40);
    check("x0_x1", dut.RISCVPipeline.RegisterFile.registers[1], 32'd0);

    // Random programs against the reference model.
    for (int t = 0; t < 15; t++) begin
      clear_model();
      for (int i = 0; i < 32; i++) m_reg[i] = $urandom;
      for (int i = 0; i < 64; i++) m_dmem[i] = $urandom;
      prog = {};
      for (int i = 0; i < 24; i++) prog.push_back(rand_instr(i, 24));
      set_prog(prog);
      start(2);
      run(130);
      compare_state($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
